// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the unified memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [MASK_W-1:0] dm_w_mask;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [MASK_W-1:0] mem_w_mask;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              pipe_stall;
    logic              err;

    modport master (
        input  if_req, if_addr, dm_req, dm_addr, dm_w_mask, dm_wdata, mem_ack, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_addr, mem_w_mask,
               mem_wdata, pipe_stall, err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_addr, dm_w_mask, dm_wdata, mem_ack, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_addr, mem_w_mask,
               mem_wdata, pipe_stall, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports,
// one transaction in flight, DM-first priority with alternation, timeout watchdog.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master b
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t     state, state_n;
    logic       last_dm;
    logic [7:0] cnt;
    logic       if_eff, dm_eff, grant_dm, grant_if, busy, done, tmo;

    // a requester's own valid pulse masks its request so it cannot be issued twice
    always_comb begin
        if_eff   = b.if_req & ~b.if_valid;
        dm_eff   = b.dm_req & ~b.dm_valid;
        busy     = state != IDLE;
        grant_dm = ~busy & dm_eff & (~if_eff | ~last_dm);
        grant_if = ~busy & if_eff & ~grant_dm;
        done     = busy & b.mem_ack;
        tmo      = busy & ~b.mem_ack & (cnt == LIMIT);
        state_n  = state;
        if (grant_dm)
            state_n = BUSY_DM;
        else if (grant_if)
            state_n = BUSY_IF;
        else if (done | tmo)
            state_n = IDLE;
    end

    assign b.pipe_stall = if_eff | dm_eff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            last_dm      <= 1'b0;
            cnt          <= '0;
            b.mem_req    <= 1'b0;
            b.mem_addr   <= '0;
            b.mem_w_mask <= '0;
            b.mem_wdata  <= '0;
            b.if_valid   <= 1'b0;
            b.dm_valid   <= 1'b0;
            b.if_rdata   <= '0;
            b.dm_rdata   <= '0;
            b.err        <= 1'b0;
        end else begin
            state      <= state_n;
            b.if_valid <= done & (state == BUSY_IF);
            b.dm_valid <= done & (state == BUSY_DM);
            if (grant_dm | grant_if) begin
                b.mem_req    <= 1'b1;
                b.mem_addr   <= grant_dm ? b.dm_addr : b.if_addr;
                b.mem_w_mask <= grant_dm ? b.dm_w_mask : '0;
                b.mem_wdata  <= grant_dm ? b.dm_wdata : '0;
                last_dm      <= grant_dm;
                cnt          <= '0;
            end else if (done | tmo) begin
                b.mem_req <= 1'b0;
            end
            if (busy & ~b.mem_ack)
                cnt <= cnt + 8'd1;
            if (tmo)
                b.err <= 1'b1;
            if (done & (state == BUSY_IF))
                b.if_rdata <= b.mem_rdata;
            // stores complete without disturbing the last load result
            if (done & (state == BUSY_DM) & (b.mem_w_mask == '0))
                b.dm_rdata <= b.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single transactions plus directed sequences for
// simultaneous requests, fairness, timeout and reset mid-transaction.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) b ();
    mem_port_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .rst(rst), .b(b));

    typedef struct {
        logic        is_dm;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] wdata;
        logic [63:0] mdata;
        int          delay;
        logic [7:0]  exp_mask;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mem_req"}, 64'(b.mem_req), 64'd0);
        chk({tag, " mem_addr"}, 64'(b.mem_addr), 64'd0);
        chk({tag, " mem_w_mask"}, 64'(b.mem_w_mask), 64'd0);
        chk({tag, " mem_wdata"}, b.mem_wdata, 64'd0);
        chk({tag, " if_valid"}, 64'(b.if_valid), 64'd0);
        chk({tag, " dm_valid"}, 64'(b.dm_valid), 64'd0);
        chk({tag, " if_rdata"}, b.if_rdata, 64'd0);
        chk({tag, " dm_rdata"}, b.dm_rdata, 64'd0);
        chk({tag, " err"}, 64'(b.err), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        b.if_req    = ~v.is_dm;
        b.dm_req    = v.is_dm;
        b.if_addr   = v.is_dm ? 32'h0 : v.addr;
        b.dm_addr   = v.is_dm ? v.addr : 32'h0;
        b.dm_w_mask = v.mask;
        b.dm_wdata  = v.wdata;
        #1;
        chk({t, " stall before grant"}, 64'(b.pipe_stall), 64'd1);
        tick;
        chk({t, " mem_req"}, 64'(b.mem_req), 64'd1);
        chk({t, " mem_addr"}, 64'(b.mem_addr), 64'(v.addr));
        chk({t, " mem_w_mask"}, 64'(b.mem_w_mask), 64'(v.exp_mask));
        if (v.is_dm) chk({t, " mem_wdata"}, b.mem_wdata, v.wdata);
        chk({t, " stall busy"}, 64'(b.pipe_stall), 64'd1);
        for (int i = 0; i < v.delay; i++) begin
            tick;
            chk({t, " mem_req held"}, 64'(b.mem_req), 64'd1);
            chk({t, " no early valid"}, 64'(b.if_valid | b.dm_valid), 64'd0);
        end
        b.mem_ack   = 1'b1;
        b.mem_rdata = v.mdata;
        tick;
        b.mem_ack = 1'b0;
        chk({t, " valid"}, 64'(v.is_dm ? b.dm_valid : b.if_valid), 64'd1);
        chk({t, " other valid"}, 64'(v.is_dm ? b.if_valid : b.dm_valid), 64'd0);
        chk({t, " rdata"}, v.is_dm ? b.dm_rdata : b.if_rdata, v.exp_rdata);
        chk({t, " stall dropped"}, 64'(b.pipe_stall), 64'd0);
        chk({t, " mem_req low"}, 64'(b.mem_req), 64'd0);
        b.if_req = 1'b0;
        b.dm_req = 1'b0;
        tick;
        chk({t, " valid one cycle"}, 64'(b.if_valid | b.dm_valid), 64'd0);
        chk({t, " no reissue"}, 64'(b.mem_req), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] grants[6];
        int g;
        vecs[0] = '{1'b0, 32'h100,  8'hFF, 64'h0, 64'h00000013_00000093, 0, 8'h00, 64'h00000013_00000093};
        vecs[1] = '{1'b1, 32'h2000, 8'h00, 64'h0, 64'h11223344_55667788, 1, 8'h00, 64'h11223344_55667788};
        vecs[2] = '{1'b1, 32'h3004, 8'h0F, 64'hDEADBEEF, 64'hBADBADBA_DBADBAD0, 0, 8'h0F, 64'h11223344_55667788};
        vecs[3] = '{1'b0, 32'h104,  8'h00, 64'hFFFF, 64'hA5A5A5A5_5A5A5A5A, 3, 8'h00, 64'hA5A5A5A5_5A5A5A5A};
        vecs[4] = '{1'b1, 32'h2008, 8'h00, 64'h0, 64'h01234567_89ABCDEF, 2, 8'h00, 64'h01234567_89ABCDEF};
        vecs[5] = '{1'b0, 32'h108,  8'h00, 64'h0, 64'hCAFEF00D_12345678, 0, 8'h00, 64'hCAFEF00D_12345678};

        b.if_req = 0; b.if_addr = 0; b.dm_req = 0; b.dm_addr = 0;
        b.dm_w_mask = 0; b.dm_wdata = 0; b.mem_ack = 0; b.mem_rdata = 0;
        #1;
        chk_zero("reset");
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk_zero("after reset");
        chk("reset stall", 64'(b.pipe_stall), 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // simultaneous requests with last_dm = 0: DM first, IF granted in the dm_valid cycle
        b.if_req = 1; b.if_addr = 32'h100;
        b.dm_req = 1; b.dm_addr = 32'h2000; b.dm_w_mask = 0;
        tick;
        chk("sim first grant", 64'(b.mem_addr), 64'h2000);
        b.mem_ack = 1; b.mem_rdata = 64'h77;
        tick;
        b.mem_ack = 0;
        chk("sim dm_valid", 64'(b.dm_valid), 64'd1);
        chk("sim dm_rdata", b.dm_rdata, 64'h77);
        chk("sim stall for if", 64'(b.pipe_stall), 64'd1);
        chk("sim mem_req gap", 64'(b.mem_req), 64'd0);
        b.dm_req = 0;
        tick;
        chk("sim if mem_req", 64'(b.mem_req), 64'd1);
        chk("sim if addr", 64'(b.mem_addr), 64'h100);
        chk("sim if mask", 64'(b.mem_w_mask), 64'd0);
        b.mem_ack = 1; b.mem_rdata = 64'h88;
        tick;
        b.mem_ack = 0;
        chk("sim if_valid", 64'(b.if_valid), 64'd1);
        chk("sim if_rdata", b.if_rdata, 64'h88);
        b.if_req = 0;
        tick;

        // fairness: both held, memory acks immediately
        b.if_req = 1; b.if_addr = 32'h500;
        b.dm_req = 1; b.dm_addr = 32'h600;
        g = 0;
        for (int c = 0; c < 40 && g < 6; c++) begin
            tick;
            if (b.mem_req && !b.mem_ack) begin
                grants[g] = b.mem_addr;
                g++;
                b.mem_ack = 1;
                b.mem_rdata = 64'(c);
            end else begin
                b.mem_ack = 0;
            end
        end
        tick;
        b.mem_ack = 0; b.if_req = 0; b.dm_req = 0;
        tick;
        chk("fair grant count", 64'(g), 64'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("fair grant%0d", i), 64'(grants[i]), (i % 2 == 0) ? 64'h600 : 64'h500);
        chk("fair idle", 64'(b.mem_req), 64'd0);

        // timeout with TIMEOUT=4: no ack, err, re-issue, later ack
        b.dm_req = 1; b.dm_addr = 32'h4000; b.dm_w_mask = 0;
        tick;
        chk("tmo grant", 64'(b.mem_req), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("tmo wait%0d err", i), 64'(b.err), 64'd0);
            chk($sformatf("tmo wait%0d mem_req", i), 64'(b.mem_req), 64'd1);
        end
        tick;
        chk("tmo err", 64'(b.err), 64'd1);
        chk("tmo mem_req dropped", 64'(b.mem_req), 64'd0);
        chk("tmo no valid", 64'(b.dm_valid), 64'd0);
        chk("tmo still stalled", 64'(b.pipe_stall), 64'd1);
        tick;
        chk("tmo reissue", 64'(b.mem_req), 64'd1);
        chk("tmo reissue addr", 64'(b.mem_addr), 64'h4000);
        b.mem_ack = 1; b.mem_rdata = 64'h4242;
        tick;
        b.mem_ack = 0;
        chk("tmo late complete", 64'(b.dm_valid), 64'd1);
        chk("tmo late rdata", b.dm_rdata, 64'h4242);
        b.dm_req = 0;
        tick;
        chk("tmo err sticky", 64'(b.err), 64'd1);

        // reset mid-transaction, then a late ack
        b.dm_req = 1; b.dm_addr = 32'h5000;
        tick;
        chk("rst grant", 64'(b.mem_req), 64'd1);
        rst = 0;
        #1;
        chk_zero("mid reset");
        b.dm_req = 0;
        tick;
        chk_zero("held reset");
        rst = 1;
        tick;
        b.mem_ack = 1; b.mem_rdata = 64'h9999;
        tick;
        b.mem_ack = 0;
        chk("late ack dm_valid", 64'(b.dm_valid), 64'd0);
        chk("late ack dm_rdata", b.dm_rdata, 64'd0);
        chk("late ack mem_req", 64'(b.mem_req), 64'd0);
        tick;
        chk("late ack valid later", 64'(b.dm_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
